// File: rtl/flash_read_ctrl_pkg.sv
// Shared types and constants for the parallel NOR flash read controller.
package flash_read_ctrl_pkg;

  localparam int FLASH_ADDR_W = 22;  // word address pins [22:1]
  localparam int FLASH_WORD_W = 16;  // x16 data bus

  localparam logic [FLASH_WORD_W-1:0] CMD_READ_ARRAY_DEFAULT = 16'h00FF;

  typedef enum logic [2:0] {
    ST_INIT_SETUP = 3'd0,
    ST_CMD_WR     = 3'd1,
    ST_CMD_HOLD   = 3'd2,
    ST_IDLE       = 3'd3,
    ST_RD_WAIT    = 3'd4,
    ST_RD_END     = 3'd5
  } state_t;

  // Largest of three cycle counts; sizes the shared state timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/flash_read_ctrl_timer.sv
// Cycle timer: counts clocks since the last clear and flags the cycle in
// which the count reaches 'limit' clocks. Saturates instead of wrapping.
module flash_cycle_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] cnt;

  // Count clocks spent since the last clear; hold at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt != {W{1'b1}}) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Current cycle is the last one of a 'limit'-cycle interval (limit >= 1).
  assign expired = (({1'b0, cnt} + {{W{1'b0}}, 1'b1}) == {1'b0, limit});

endmodule

// File: rtl/flash_read_ctrl.sv
// Word-mode read controller for a parallel NOR flash. Issues Read Array after
// reset, then performs one 16-bit asynchronous read per accepted request.
// Strobes are registered from the next-state decode so every pin is a flop.
//
// Handshake: rd_req is only looked at while IDLE (busy=0); a request seen in
// IDLE is accepted on that edge and rd_addr is captured with it. rd_done
// pulses for one cycle when rd_data has been updated; there is no
// backpressure on the result side.
module flash_read_ctrl
  import flash_read_ctrl_pkg::*;
#(
  parameter int                ACCESS_CYCLES  = 4,
  parameter int                WE_CYCLES      = 2,
  parameter int                SETUP_CYCLES   = 1,
  parameter logic [15:0]       CMD_READ_ARRAY = CMD_READ_ARRAY_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_req,
  input  logic [FLASH_ADDR_W-1:0] rd_addr,
  output logic [FLASH_WORD_W-1:0] rd_data,
  output logic                    rd_done,
  output logic                    busy,
  output logic                    init_done,
  output logic [FLASH_ADDR_W-1:0] flash_addr,
  input  logic [FLASH_WORD_W-1:0] flash_dq_in,
  output logic [FLASH_WORD_W-1:0] flash_dq_out,
  output logic                    flash_dq_oe,
  output logic                    flash_ce_n,
  output logic                    flash_oe_n,
  output logic                    flash_we_n,
  output logic                    flash_byte_n,
  output logic                    flash_vpen,
  output logic                    flash_rp_n,
  output state_t                  dbg_state
);

  localparam int CNT_W = $clog2(max3(ACCESS_CYCLES, WE_CYCLES, SETUP_CYCLES) + 1);

  state_t             state_q, state_next;
  logic [CNT_W-1:0]   limit;
  logic               expired;
  logic               capture;

  logic                    ce_n_d, oe_n_d, we_n_d, dq_oe_d, busy_d;
  logic [FLASH_WORD_W-1:0] dq_out_d;

  assign flash_byte_n = 1'b1;
  assign flash_vpen   = 1'b0;
  assign dbg_state    = state_q;
  assign capture      = (state_q == ST_RD_WAIT) && expired;

  // Duration of the current state in clocks.
  always_comb begin
    limit = CNT_W'(1);
    case (state_q)
      ST_INIT_SETUP, ST_CMD_HOLD: limit = CNT_W'(SETUP_CYCLES);
      ST_CMD_WR:                  limit = CNT_W'(WE_CYCLES);
      ST_RD_WAIT:                 limit = CNT_W'(ACCESS_CYCLES);
      default:                    limit = CNT_W'(1);
    endcase
  end

  flash_cycle_timer #(.W(CNT_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_next != state_q),
    .limit   (limit),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_INIT_SETUP;
    else     state_q <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state_q;
    case (state_q)
      ST_INIT_SETUP: if (expired) state_next = ST_CMD_WR;
      ST_CMD_WR:     if (expired) state_next = ST_CMD_HOLD;
      ST_CMD_HOLD:   if (expired) state_next = ST_IDLE;
      ST_IDLE:       if (rd_req)  state_next = ST_RD_WAIT;
      ST_RD_WAIT:    if (expired) state_next = ST_RD_END;
      ST_RD_END:                  state_next = ST_IDLE;
      default:                    state_next = ST_INIT_SETUP;
    endcase
  end

  // Pin values for the state being entered; registered below.
  always_comb begin
    ce_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    dq_oe_d  = 1'b0;
    dq_out_d = '0;
    busy_d   = 1'b1;
    case (state_next)
      ST_CMD_WR: begin
        ce_n_d   = 1'b0;
        we_n_d   = 1'b0;
        dq_oe_d  = 1'b1;
        dq_out_d = CMD_READ_ARRAY;
      end
      // Keep driving the command word through the WE# hold time.
      ST_CMD_HOLD: begin
        dq_oe_d  = 1'b1;
        dq_out_d = CMD_READ_ARRAY;
      end
      ST_IDLE:    busy_d = 1'b0;
      ST_RD_WAIT: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Registered strobes, bus drive and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      flash_ce_n   <= 1'b1;
      flash_oe_n   <= 1'b1;
      flash_we_n   <= 1'b1;
      flash_dq_oe  <= 1'b0;
      flash_dq_out <= '0;
      busy         <= 1'b1;
      init_done    <= 1'b0;
    end else begin
      flash_ce_n   <= ce_n_d;
      flash_oe_n   <= oe_n_d;
      flash_we_n   <= we_n_d;
      flash_dq_oe  <= dq_oe_d;
      flash_dq_out <= dq_out_d;
      busy         <= busy_d;
      if (state_next == ST_IDLE) init_done <= 1'b1;
    end
  end

  // Address latch and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      flash_addr <= '0;
      rd_data    <= '0;
      rd_done    <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && rd_req) flash_addr <= rd_addr;
      else if (state_next == ST_CMD_WR) flash_addr <= '0;
      if (capture) rd_data <= flash_dq_in;
      rd_done <= capture;
    end
  end

  // Flash reset pin follows the controller reset, one clock later.
  always_ff @(posedge clk) begin
    flash_rp_n <= ~rst;
  end

endmodule

// File: tb/tb_flash_read_ctrl.sv
// Self-checking bench for flash_read_ctrl with a behavioural flash model.
module tb_flash_read_ctrl;
  import flash_read_ctrl_pkg::*;

  localparam int ACCESS = 4;
  localparam int WE_LEN = 2;
  localparam int SETUP  = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        rd_req = 1'b0;
  logic [21:0] rd_addr = '0;
  logic [15:0] rd_data;
  logic        rd_done, busy, init_done;
  logic [21:0] flash_addr;
  logic [15:0] flash_dq_in;
  logic [15:0] flash_dq_out;
  logic        flash_dq_oe, flash_ce_n, flash_oe_n, flash_we_n;
  logic        flash_byte_n, flash_vpen, flash_rp_n;
  state_t      dbg_state;

  flash_read_ctrl dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_done(rd_done), .busy(busy), .init_done(init_done),
    .flash_addr(flash_addr), .flash_dq_in(flash_dq_in), .flash_dq_out(flash_dq_out),
    .flash_dq_oe(flash_dq_oe), .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n),
    .flash_we_n(flash_we_n), .flash_byte_n(flash_byte_n), .flash_vpen(flash_vpen),
    .flash_rp_n(flash_rp_n), .dbg_state(dbg_state)
  );

  // ---------------- flash model ----------------
  logic [15:0] mem [int];

  function automatic logic [15:0] model_word(input logic [21:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return a[15:0] ^ {a[21:16], 10'h2A5};
  endfunction

  // Strobes only move on posedge, so presenting data on negedge is early enough.
  always @(negedge clk)
    flash_dq_in = (!flash_ce_n && !flash_oe_n) ? model_word(flash_addr) : 16'hFFFF;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];
  int n_done = 0;
  int last_done_cyc = 0;
  int we_len = 0;
  int we_pulses = 0;
  int rd_len = 0;
  logic rd_abort = 1'b0;
  logic prev_dq_oe = 1'b0;
  logic prev_init = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus protocol checks and read-result scoreboard, every cycle.
  always @(negedge clk) begin
    check("dq_oe_with_oe_n_low", 32'(flash_dq_oe & ~flash_oe_n), 0);
    check("byte_n", 32'(flash_byte_n), 1);
    check("vpen", 32'(flash_vpen), 0);
    if (!flash_we_n) begin
      we_len++;
      check("we_dq_out", 32'(flash_dq_out), 32'h00FF);
      check("we_dq_oe", 32'(flash_dq_oe), 1);
      check("we_oe_n", 32'(flash_oe_n), 1);
    end else if (we_len != 0) begin
      check("we_pulse_len", we_len, WE_LEN);
      we_pulses++;
      we_len = 0;
    end
    if (!flash_ce_n && !flash_oe_n) begin
      rd_len++;
      if (rst) rd_abort = 1'b1;
    end else if (rd_len != 0) begin
      if (!rd_abort) check("ce_oe_low_len", rd_len, ACCESS);
      rd_len = 0;
      rd_abort = 1'b0;
    end
    if (init_done && !prev_init)
      check("init_after_hold", 32'({prev_dq_oe, flash_dq_oe}), 32'b10);
    prev_init = init_done;
    prev_dq_oe = flash_dq_oe;
    if (rd_done) begin
      n_done++;
      last_done_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL spurious_rd_done: got rd_done=1 data 0x%0h expected no pending read", rd_data);
      end else begin
        check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int k;
    for (k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (!busy) break;
    end
    if (k == 30) check("wait_idle_timeout", 32'(busy), 0);
  endtask

  task automatic wait_done(input int n0);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk); #1;
      if (n_done != n0) break;
    end
    if (n_done == n0) check("rd_done_timeout", n_done, n0 + 1);
  endtask

  task automatic do_read(input logic [21:0] a, input logic [15:0] exp);
    int t, n0;
    wait_idle();
    rd_req = 1'b1;
    rd_addr = a;
    t = cyc;
    n0 = n_done;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    rd_req = 1'b0;
    rd_addr = 22'($urandom);  // must not disturb the accepted read
    wait_done(n0);
    check("read_latency", last_done_cyc - t, ACCESS + 1);
  endtask

  typedef struct {
    logic [21:0] addr;
    logic [15:0] data;
  } vec_t;
  vec_t vec[6];

  // ---------------- test sequence ----------------
  initial begin
    int t0, n0;
    int d[3];
    logic [21:0] a;

    mem[32'h000010] = 16'hBEEF;
    mem[32'h000000] = 16'h1111;
    mem[32'h000001] = 16'h2222;
    mem[32'h000002] = 16'h3333;
    mem[32'h3FFFFF] = 16'hA5A5;
    mem[32'h2AAAAA] = 16'h5A5A;

    vec[0] = '{22'h000010, 16'hBEEF};
    vec[1] = '{22'h000000, 16'h1111};
    vec[2] = '{22'h000001, 16'h2222};
    vec[3] = '{22'h000002, 16'h3333};
    vec[4] = '{22'h3FFFFF, 16'hA5A5};
    vec[5] = '{22'h2AAAAA, 16'h5A5A};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_rd_done", 32'(rd_done), 0);
    check("rst_busy", 32'(busy), 1);
    check("rst_init_done", 32'(init_done), 0);
    check("rst_flash_addr", 32'(flash_addr), 0);
    check("rst_dq_out", 32'(flash_dq_out), 0);
    check("rst_dq_oe", 32'(flash_dq_oe), 0);
    check("rst_strobes", 32'({flash_ce_n, flash_oe_n, flash_we_n}), 32'b111);
    check("rst_rp_n", 32'(flash_rp_n), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_INIT_SETUP));

    // Init: one WE# pulse carrying Read Array, init_done after the hold
    @(posedge clk); #1;
    rst = 1'b0;
    t0 = cyc;
    for (int k = 0; k < 30 && !init_done; k++) begin @(negedge clk); #1; end
    check("init_done_time", cyc - t0, SETUP + WE_LEN + SETUP);
    check("init_we_pulses", we_pulses, 1);
    check("rp_n_released", 32'(flash_rp_n), 1);

    // Single read, result held afterwards
    do_read(22'h000010, 16'hBEEF);
    repeat (4) @(negedge clk);
    check("rd_data_held", 32'(rd_data), 32'hBEEF);
    check("idle_after_read", 32'(busy), 0);

    // Table of address/data vectors
    for (int i = 0; i < 6; i++) do_read(vec[i].addr, vec[i].data);

    // rd_req held high over three addresses
    wait_idle();
    rd_req = 1'b1;
    rd_addr = 22'h0;
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h2222);
    exp_q.push_back(16'h3333);
    for (int i = 0; i < 3; i++) begin
      wait_done(n_done);
      d[i] = last_done_cyc;
      if (i == 0) rd_addr = 22'h1;
      if (i == 1) begin
        rd_addr = 22'h2;
        @(posedge clk); @(posedge clk); #1;
        rd_req = 1'b0;
      end
    end
    check("b2b_gap_1", d[1] - d[0], ACCESS + 2);
    check("b2b_gap_2", d[2] - d[1], ACCESS + 2);

    // Request pulsed during RD_WAIT is ignored
    wait_idle();
    n0 = n_done;
    rd_req = 1'b1;
    rd_addr = 22'h000010;
    exp_q.push_back(16'hBEEF);
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(posedge clk); #1;
    rd_req = 1'b1;
    rd_addr = 22'h3FFFFF;
    @(posedge clk); #1;
    rd_req = 1'b0;
    wait_done(n0);
    repeat (8) @(negedge clk);
    check("busy_req_done_count", n_done - n0, 1);
    check("busy_req_addr", 32'(flash_addr), 32'h000010);

    // Reset in the second RD_WAIT cycle
    wait_idle();
    n0 = n_done;
    rd_req = 1'b1;
    rd_addr = 22'h000123;
    exp_q.push_back(model_word(22'h000123));
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_strobes", 32'({flash_ce_n, flash_oe_n, flash_we_n}), 32'b111);
    check("midrst_dq_oe", 32'(flash_dq_oe), 0);
    check("midrst_busy", 32'(busy), 1);
    check("midrst_rd_done", 32'(rd_done), 0);
    check("midrst_init_done", 32'(init_done), 0);
    exp_q.delete();
    we_pulses = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 30 && !init_done; k++) begin @(negedge clk); #1; end
    check("reinit_done", 32'(init_done), 1);
    check("reinit_we_pulses", we_pulses, 1);
    check("midrst_no_done", n_done - n0, 0);

    // Randomized reads against the flash model
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      a = 22'($urandom_range(0, 32'h3FFFFF));
      do_read(a, model_word(a));
    end

    repeat (10) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Overall time limit
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
